// File: rtl/max7219_sequencer_pkg.sv
// Shared MAX7219 register map, sequencer/write-port state encodings and the
// write descriptor handed from the sequencer to the write port.
package max7219_sequencer_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int INIT_WRITES = 6;

  // ST_SHDN carries the single shutdown write issued on enable fall.
  typedef enum logic [2:0] {
    ST_OFF, ST_INIT, ST_READY, ST_FRAME, ST_SHDN
  } seq_state_t;

  typedef enum logic [1:0] {
    WP_IDLE, WP_ISSUE, WP_WAIT_ACK, WP_WAIT_DONE
  } wp_state_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max7219_write_port.sv
// One register write to the serial driver: strobe, wait for busy to rise
// (bounded by ACK_TIMEOUT), then wait for busy to fall.
module max7219_write_port
  import max7219_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 7
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_req,
  input  wr_t        i_wr,
  input  logic       i_drv_busy,
  output logic       o_drv_stb,
  output logic [3:0] o_drv_addr,
  output logic [7:0] o_drv_data,
  output logic       o_active,
  output logic       o_done,
  output logic       o_timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  wp_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_addr;
  logic [7:0]      r_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= WP_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Address/data latch at acceptance and hold until the next acceptance.
      if (r_state == WP_IDLE && i_req && !i_drv_busy) begin
        r_addr <= i_wr.addr;
        r_data <= i_wr.data;
      end
      if (r_state == WP_ISSUE)         r_cnt <= '0;
      else if (r_state == WP_WAIT_ACK) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_timeout   = 1'b0;
    case (r_state)
      WP_IDLE:      if (i_req && !i_drv_busy) w_state_nxt = WP_ISSUE;
      WP_ISSUE:     w_state_nxt = WP_WAIT_ACK;
      WP_WAIT_ACK: begin
        if (i_drv_busy) begin
          w_state_nxt = WP_WAIT_DONE;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = WP_IDLE;
          o_done      = 1'b1;
          o_timeout   = 1'b1;
        end
      end
      WP_WAIT_DONE: begin
        if (!i_drv_busy) begin
          w_state_nxt = WP_IDLE;
          o_done      = 1'b1;
        end
      end
      default:      w_state_nxt = WP_IDLE;
    endcase
  end

  assign o_drv_stb  = (r_state == WP_ISSUE);
  assign o_drv_addr = r_addr;
  assign o_drv_data = r_data;
  assign o_active   = (r_state != WP_IDLE);

endmodule

// File: rtl/max7219_sequencer.sv
// MAX7219 init/refresh sequencer: runs the init table on enable, rewrites
// intensity and all digits from a shadow snapshot per refresh, shuts down on disable.
module max7219_sequencer
  import max7219_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int ACK_TIMEOUT = 7
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_refresh_stb,
  input  logic [3:0]              i_intensity,
  input  logic [8*NUM_DIGITS-1:0] i_digits,
  output logic                    o_init_done,
  output logic                    o_ready,
  output logic                    o_err,
  output logic                    o_drv_stb,
  output logic [3:0]              o_drv_addr,
  output logic [7:0]              o_drv_data,
  input  logic                    i_drv_busy
);

  localparam int NW = max2(INIT_WRITES, NUM_DIGITS + 1);
  localparam int IW = $clog2(NW);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  seq_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_idx;
  logic          r_init_done, r_err, r_pend;
  logic [3:0]    r_sh_int;
  logic [7:0]    r_sh_dig [NUM_DIGITS];

  wr_t           w_wr;
  logic          w_req, w_active, w_done, w_timeout, w_last;
  logic          w_adv, w_clr_idx, w_snap, w_set_done;
  logic [DW-1:0] w_didx;

  max7219_write_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_req      (w_req),
    .i_wr       (w_wr),
    .i_drv_busy (i_drv_busy),
    .o_drv_stb  (o_drv_stb),
    .o_drv_addr (o_drv_addr),
    .o_drv_data (o_drv_data),
    .o_active   (w_active),
    .o_done     (w_done),
    .o_timeout  (w_timeout)
  );

  assign w_didx = DW'(r_idx - 1'b1);

  // Write descriptor for the current table entry.
  always_comb begin
    w_wr.addr = REG_NOOP;
    w_wr.data = 8'h00;
    w_last    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_last = (r_idx == IW'(INIT_WRITES - 1));
        case (r_idx)
          IW'(0):  w_wr = '{REG_SHUTDOWN,  8'h00};
          IW'(1):  w_wr = '{REG_TEST,      8'h00};
          IW'(2):  w_wr = '{REG_DECODE,    8'h00};
          IW'(3):  w_wr = '{REG_SCANLIMIT, 8'(NUM_DIGITS - 1)};
          IW'(4):  w_wr = '{REG_INTENSITY, {4'h0, i_intensity}};
          default: w_wr = '{REG_SHUTDOWN,  8'h01};
        endcase
      end
      ST_FRAME: begin
        w_last = (r_idx == IW'(NUM_DIGITS));
        if (r_idx == '0) w_wr = '{REG_INTENSITY, {4'h0, r_sh_int}};
        else             w_wr = '{REG_DIGIT0 + 4'(r_idx) - 4'd1, r_sh_dig[w_didx]};
      end
      ST_SHDN: w_wr = '{REG_SHUTDOWN, 8'h00};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_adv       = 1'b0;
    w_clr_idx   = 1'b0;
    w_snap      = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (i_enable) begin
          w_state_nxt = ST_INIT;
          w_clr_idx   = 1'b1;
        end
      end
      ST_INIT, ST_FRAME: begin
        // Withholding the request on disable lets an in-flight write finish.
        w_req = i_enable;
        if (w_done) begin
          if (!i_enable) begin
            w_state_nxt = ST_SHDN;
          end else if (w_last) begin
            w_state_nxt = ST_READY;
            w_set_done  = (r_state == ST_INIT);
          end else begin
            w_adv = 1'b1;
          end
        end else if (!w_active && !i_enable) begin
          w_state_nxt = ST_SHDN;
        end
      end
      ST_READY: begin
        if (!i_enable) begin
          w_state_nxt = ST_SHDN;
        end else if (i_refresh_stb || r_pend) begin
          w_state_nxt = ST_FRAME;
          w_clr_idx   = 1'b1;
          w_snap      = 1'b1;
        end
      end
      ST_SHDN: begin
        w_req = 1'b1;
        if (w_done) w_state_nxt = ST_OFF;
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= ST_OFF;
      r_idx       <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= 1'b0;
      r_sh_int    <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) r_sh_dig[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_idx)  r_idx <= '0;
      else if (w_adv) r_idx <= r_idx + 1'b1;
      if (w_set_done)                                   r_init_done <= 1'b1;
      else if (r_state == ST_SHDN && w_state_nxt == ST_OFF) r_init_done <= 1'b0;
      if (w_timeout) r_err <= 1'b1;
      if (r_state == ST_SHDN || r_state == ST_OFF || w_snap)
        r_pend <= 1'b0;
      else if (i_refresh_stb && (r_state == ST_INIT || r_state == ST_FRAME))
        r_pend <= 1'b1;
      if (w_snap) begin
        r_sh_int <= i_intensity;
        for (int k = 0; k < NUM_DIGITS; k++) r_sh_dig[k] <= i_digits[8*k +: 8];
      end
    end
  end

  assign o_init_done = r_init_done;
  assign o_err       = r_err;
  assign o_ready     = (r_state == ST_READY) && r_init_done && !r_pend;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench: driver model with a 17-cycle busy window (or mute), write log
// of every strobe, and checks of init/frame/coalesce/disable/timeout/reset.
module tb_max7219_sequencer;

  logic        clk = 1'b0;
  logic        i_reset_n, i_enable, i_refresh_stb;
  logic [3:0]  i_intensity;
  logic [63:0] i_digits;
  logic        o_init_done, o_ready, o_err, o_drv_stb;
  logic [3:0]  o_drv_addr;
  logic [7:0]  o_drv_data;
  logic        i_drv_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max7219_sequencer #(.NUM_DIGITS(8), .ACK_TIMEOUT(7)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_enable      (i_enable),
    .i_refresh_stb (i_refresh_stb),
    .i_intensity   (i_intensity),
    .i_digits      (i_digits),
    .o_init_done   (o_init_done),
    .o_ready       (o_ready),
    .o_err         (o_err),
    .o_drv_stb     (o_drv_stb),
    .o_drv_addr    (o_drv_addr),
    .o_drv_data    (o_drv_data),
    .i_drv_busy    (i_drv_busy)
  );

  // Driver model: busy for 17 cycles after each strobe unless muted.
  int   cyc  = 0;
  int   bcnt = 0;
  logic mute = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_drv_stb && !mute) bcnt <= 17;
    else if (bcnt > 0)      bcnt <= bcnt - 1;
  end
  assign i_drv_busy = (bcnt != 0);

  logic [11:0] wlog [256];
  int          wcyc [256];
  int          n = 0;
  always @(posedge clk) begin
    if (o_drv_stb && n < 256) begin
      wlog[n] <= {o_drv_addr, o_drv_data};
      wcyc[n] <= cyc;
      n       <= n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_refresh();
    i_refresh_stb = 1'b1;
    tick(1);
    i_refresh_stb = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (o_ready !== 1'b1 && t < 3000) begin tick(1); t++; end
    chk(tag, 32'(o_ready), 32'd1);
  endtask

  task automatic wait_init(input logic v, input string tag);
    int t = 0;
    while (o_init_done !== v && t < 3000) begin tick(1); t++; end
    chk(tag, 32'(o_init_done), 32'(v));
  endtask

  task automatic wait_n(input int target, input string tag);
    int t = 0;
    while (n < target && t < 3000) begin tick(1); t++; end
    chk(tag, 32'(n >= target), 32'd1);
  endtask

  logic [11:0] exp_init [6] = '{12'hC00, 12'hF00, 12'h900, 12'hB07, 12'hA05, 12'hC01};
  int base;

  initial begin
    i_reset_n     = 1'b0;
    i_enable      = 1'b0;
    i_refresh_stb = 1'b0;
    i_intensity   = 4'h5;
    i_digits      = 64'h0102030405060708;
    tick(3);
    chk("rst_stb",   32'(o_drv_stb),   32'd0);
    chk("rst_addr",  32'(o_drv_addr),  32'd0);
    chk("rst_data",  32'(o_drv_data),  32'd0);
    chk("rst_done",  32'(o_init_done), 32'd0);
    chk("rst_ready", 32'(o_ready),     32'd0);
    chk("rst_err",   32'(o_err),       32'd0);

    // Refresh in OFF must be dropped, and nothing may be written while off.
    i_reset_n = 1'b1;
    tick(2);
    pulse_refresh();
    tick(3);
    chk("off_no_writes", 32'(n), 32'd0);

    base     = n;
    i_enable = 1'b1;
    wait_init(1'b1, "init_complete");
    chk("init_count", 32'(n - base), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("init_w%0d", i), 32'(wlog[base+i]), 32'(exp_init[i]));
    chk("init_ready", 32'(o_ready), 32'd1);
    chk("init_err",   32'(o_err),   32'd0);

    // Frame from snapshot; inputs change mid-frame.
    base = n;
    pulse_refresh();
    tick(5);
    i_digits    = 64'hFFFF_FFFF_FFFF_FFFF;
    i_intensity = 4'hF;
    wait_ready("frame_ready");
    chk("frame_count", 32'(n - base), 32'd9);
    chk("frame_w0", 32'(wlog[base]), 32'h0A05);
    for (int k = 1; k <= 8; k++)
      chk($sformatf("frame_w%0d", k), 32'(wlog[base+k]), 32'({4'(k), 8'(9 - k)}));
    chk("frame_spacing", 32'(wcyc[base+1] - wcyc[base]), 32'd20);

    // Three strobes during a frame coalesce into one extra frame.
    i_intensity = 4'h3;
    i_digits    = 64'h1122334455667788;
    base = n;
    pulse_refresh();
    tick(20);
    pulse_refresh();
    tick(3);
    pulse_refresh();
    tick(3);
    pulse_refresh();
    wait_ready("coal_ready");
    chk("coal_count", 32'(n - base), 32'd18);
    chk("coal_f2_int", 32'(wlog[base+9]),  32'h0A03);
    chk("coal_f2_d1",  32'(wlog[base+10]), 32'h0188);
    chk("coal_f2_d8",  32'(wlog[base+17]), 32'h0811);
    tick(100);
    chk("coal_no_more", 32'(n - base), 32'd18);

    // Disable during digit 3: it completes, then shutdown, then silence.
    i_intensity = 4'h5;
    i_digits    = 64'h0102030405060708;
    base = n;
    pulse_refresh();
    wait_n(base + 4, "dis_reach_d3");
    i_enable = 1'b0;
    wait_init(1'b0, "dis_done_low");
    tick(100);
    chk("dis_count",   32'(n - base), 32'd5);
    chk("dis_d3",      32'(wlog[base+3]), 32'h0306);
    chk("dis_shdn",    32'(wlog[base+4]), 32'h0C00);
    chk("dis_spacing", 32'(wcyc[base+4] - wcyc[base+3]), 32'd20);
    chk("dis_ready",   32'(o_ready), 32'd0);
    chk("dis_err",     32'(o_err),   32'd0);

    // Driver never acknowledges: every write times out, init still completes.
    mute     = 1'b1;
    base     = n;
    i_enable = 1'b1;
    wait_init(1'b1, "to_init_complete");
    chk("to_count", 32'(n - base), 32'd6);
    chk("to_err",   32'(o_err),    32'd1);
    chk("to_first", 32'(wlog[base]),   32'h0C00);
    chk("to_last",  32'(wlog[base+5]), 32'h0C01);
    for (int i = 1; i < 6; i++)
      chk($sformatf("to_spacing%0d", i), 32'(wcyc[base+i] - wcyc[base+i-1]), 32'd9);
    tick(30);
    chk("to_err_sticky", 32'(o_err), 32'd1);
    mute = 1'b0;

    // Reset in the middle of a frame.
    base = n;
    pulse_refresh();
    wait_n(base + 3, "rstf_reach");
    i_reset_n = 1'b0;
    tick(1);
    chk("rstf_stb",   32'(o_drv_stb),   32'd0);
    chk("rstf_addr",  32'(o_drv_addr),  32'd0);
    chk("rstf_data",  32'(o_drv_data),  32'd0);
    chk("rstf_done",  32'(o_init_done), 32'd0);
    chk("rstf_ready", 32'(o_ready),     32'd0);
    chk("rstf_err",   32'(o_err),       32'd0);
    i_reset_n = 1'b1;
    base = n;
    wait_init(1'b1, "rstf_reinit");
    chk("rstf_count", 32'(n - base), 32'd6);
    chk("rstf_first", 32'(wlog[base]),   32'h0C00);
    chk("rstf_last",  32'(wlog[base+5]), 32'h0C01);
    chk("rstf_ready_after", 32'(o_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_sequencer.md
MAX7219_SEQUENCER -- requirements
Module: max7219_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 8, range 1..8: number of digit registers refreshed; also sets scan limit.
REQ-002 Parameter ACK_TIMEOUT, default 7: cycles to wait for i_drv_busy to rise after a strobe.
REQ-003 i_clk  in  1  system clock.
REQ-004 i_reset_n  in  1  synchronous, active-low reset.
REQ-005 i_enable  in  1  high = run init and accept refreshes; low = shut down sequencing.
REQ-006 i_refresh_stb  in  1  one-cycle request to rewrite intensity and all digits.
REQ-007 i_intensity  in  4  brightness code, register 0x0A value.
REQ-008 i_digits  in  8*NUM_DIGITS  segment bytes; digit k occupies bits [8k+7:8k] and goes to address k+1.
REQ-009 o_init_done  out  1  init sequence completed since last reset/enable rise.
REQ-010 o_ready  out  1  init done, no frame in progress, nothing pending.
REQ-011 o_err  out  1  sticky; set on any ACK_TIMEOUT expiry.
REQ-012 o_drv_stb  out  1  one-cycle write request to the serial driver.
REQ-013 o_drv_addr  out  4  driver register address.
REQ-014 o_drv_data  out  8  driver register data.
REQ-015 i_drv_busy  in  1  driver shifting/latching a word.

Function
REQ-016 States: OFF, INIT, READY, FRAME; each write uses sub-states ISSUE, WAIT_ACK, WAIT_DONE.
REQ-017 OFF -> INIT when i_enable=1; INIT writes in order (addr,data): (0xC,0x00) (0xF,0x00) (0x9,0x00) (0xB,NUM_DIGITS-1) (0xA,i_intensity) (0xC,0x01).
REQ-018 INIT complete -> o_init_done=1, state READY.
REQ-019 FRAME writes (0xA, intensity snapshot), then digits 1..NUM_DIGITS in ascending address order from the snapshot, then returns to READY.
REQ-020 ISSUE: entered only with i_drv_busy=0; o_drv_stb high exactly one cycle; addr/data held stable from ISSUE until WAIT_DONE exits.
REQ-021 WAIT_ACK: waits for i_drv_busy=1; after ACK_TIMEOUT cycles without it, set o_err and treat the write as complete.
REQ-022 WAIT_DONE: waits for i_drv_busy=0, then advances to the next write; no timeout.
REQ-023 Snapshot: i_digits and i_intensity captured into a shadow buffer in the cycle the frame starts; input changes during a frame have no effect on it.
REQ-024 i_refresh_stb while INIT or FRAME sets a one-deep pending flag; further strobes coalesce; pending frame starts the cycle after READY is reached.
REQ-025 i_refresh_stb in OFF is discarded.
REQ-026 i_enable falling: current write completes (through WAIT_DONE), then issue (0xC,0x00), clear o_init_done and pending, go OFF.
REQ-027 i_enable re-rising reruns the full INIT sequence.
REQ-028 Minimum gap between o_drv_stb pulses: 1 cycle after i_drv_busy falls.
REQ-029 Write counter sized for max(6, NUM_DIGITS+1) entries; no wrap beyond the last entry.

Reset
REQ-030 While i_reset_n=0 at a clock edge: state OFF, o_drv_stb=0, o_drv_addr=0, o_drv_data=0, o_init_done=0, o_ready=0, o_err=0, pending=0, shadow buffer=0.
REQ-031 Reset mid-write aborts immediately; no shutdown write is issued.

Structure
REQ-032 Shared package holds MAX7219 register addresses (NOOP 0x0, DIGIT0 0x1, DECODE 0x9, INTENSITY 0xA, SCANLIMIT 0xB, SHUTDOWN 0xC, TEST 0xF) and the state enumeration.
REQ-033 One sub-module, max7219_write_port, implements the ISSUE/WAIT_ACK/WAIT_DONE handshake and timeout; the top holds the sequencing FSM and shadow buffer.

Verification
REQ-034 Enable with NUM_DIGITS=8, i_intensity=0x5, driver model busy 17 cycles per word -> six writes C00,F00,900,B07,A05,C01 in order; then o_init_done=1, o_ready=1.
REQ-035 Refresh with i_digits=0x0102030405060708 -> writes A05, 108, 207, ..., 801; i_digits changed mid-frame does not alter the frame.
REQ-036 Three refresh strobes during one frame -> exactly one additional frame follows.
REQ-037 Driver model never asserts busy -> each write lasts ACK_TIMEOUT+2 cycles, o_err=1 and stays 1, sequence still completes.
REQ-038 i_enable dropped during digit 3 write -> digit 3 completes, then C00, o_init_done=0, no further writes.
REQ-039 i_reset_n low during FRAME -> next cycle all outputs 0, state OFF; re-enable reruns init from C00.
